// File: rtl/aes_encrypt_sequencer_pkg.sv
// Shared types, constants and AES primitive functions for the iterative encryptor.
// The primitives work on a 128-bit state whose byte n sits at bits [127-8n -: 8].
// Byte n is state row (n % 4), column (n / 4). This matches the FIPS-197 input ordering.
package aes_encrypt_sequencer_pkg;

  localparam int unsigned BlockW  = 128;
  localparam int unsigned RoundW  = 4;
  localparam int unsigned MaxKeyW = 256;

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  // Word i of the expanded key is entry i; 60 words cover AES-256, and the rest stay zero.
  typedef logic [63:0][31:0] key_sched_t;

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (b^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BlockW-1:0] byte_sub(input logic [BlockW-1:0] s);
    logic [BlockW-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
    return r;
  endfunction

  function automatic logic [BlockW-1:0] shift_rows(input logic [BlockW-1:0] s);
    logic [BlockW-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BlockW-1:0] mix_columns(input logic [BlockW-1:0] s);
    logic [BlockW-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [BlockW-1:0] add_round_key(input logic [BlockW-1:0] s,
                                                      input logic [BlockW-1:0] k);
    return s ^ k;
  endfunction

  function automatic logic [BlockW-1:0] encryption_round(input logic [BlockW-1:0] s,
                                                         input logic [BlockW-1:0] k);
    return add_round_key(mix_columns(shift_rows(byte_sub(s))), k);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 15; i++) begin
      if (i < j) r = xtime(r);
    end
    return {r, 24'h000000};
  endfunction

  // Key is left-aligned in 256 bits; nk selects AES-128/192/256 scheduling.
  function automatic key_sched_t key_expansion(input logic [MaxKeyW-1:0] key, input int nk);
    key_sched_t w;
    logic [31:0] tmp;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
    end
    for (int i = 4; i < 60; i++) begin
      if (i >= nk) begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = sub_word(rot_word(tmp)) ^ rcon(i / nk);
        end else if (nk > 6 && i % nk == 4) begin
          tmp = sub_word(tmp);
        end
        w[i] = w[i-nk] ^ tmp;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_encrypt_sequencer_if.sv
// Handshake bundle between a block producer/consumer and the AES sequencer.
//   in_valid/in_ready/in_data/in_key : plaintext + key offer (producer -> sequencer)
//   out_valid/out_ready/out_data     : ciphertext return with backpressure
//   busy/round_idx                   : status
// master = producer/consumer side, slave = sequencer side.
interface aes_encrypt_sequencer_if
  import aes_encrypt_sequencer_pkg::*;
#(
  parameter int unsigned Nk = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [BlockW-1:0] in_data;
  logic [32*Nk-1:0]  in_key;
  logic              out_valid;
  logic              out_ready;
  logic [BlockW-1:0] out_data;
  logic              busy;
  logic [RoundW-1:0] round_idx;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy, round_idx
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy, round_idx
  );

endinterface

// File: rtl/aes_encrypt_sequencer_final_round.sv
// Combinational AES final round: SubBytes -> ShiftRows -> AddRoundKey (no MixColumns).
//   state_i     : state entering the last round
//   round_key_i : last round key
//   state_o     : ciphertext
module aes_encrypt_sequencer_final_round
  import aes_encrypt_sequencer_pkg::*;
(
  input  logic [BlockW-1:0] state_i,
  input  logic [BlockW-1:0] round_key_i,
  output logic [BlockW-1:0] state_o
);

  assign state_o = add_round_key(shift_rows(byte_sub(state_i)), round_key_i);

endmodule

// File: rtl/aes_encrypt_sequencer.sv
// Iterative AES encryptor: one state register and one shared round datapath used Nr times.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of aes_encrypt_sequencer_if (plaintext/key in, ciphertext out, status)
// A block is accepted in StIdle, runs Nr-1 full rounds plus a final round in StRound, and is
// held in StDone until the consumer takes it. The key schedule is recomputed every cycle from
// the registered key, so no expanded-key storage exists.
module aes_encrypt_sequencer
  import aes_encrypt_sequencer_pkg::*;
#(
  parameter int unsigned Nk = 4
) (
  input logic                    clk,
  input logic                    rst,
  aes_encrypt_sequencer_if.slave bus
);

  localparam int unsigned Nr        = nr_of(Nk);
  localparam int unsigned KeyW      = 32 * Nk;
  localparam logic [RoundW-1:0] LastRound = RoundW'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_encrypt_sequencer: Nk must be 4, 6 or 8");
  end

  fsm_e              fsm_q;
  logic [BlockW-1:0] state_q;
  logic [KeyW-1:0]   key_q;
  logic [RoundW-1:0] rnd_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [MaxKeyW-1:0] key_ext;
  key_sched_t         sched;
  logic [5:0]         word_base;
  logic [BlockW-1:0]  round_key;
  logic [BlockW-1:0]  round_key0;
  logic [BlockW-1:0]  mid_state;
  logic [BlockW-1:0]  final_state;

  // Left-align the key so the schedule always reads word 0 from the top bits.
  assign key_ext = MaxKeyW'(key_q) << (MaxKeyW - KeyW);
  assign sched   = key_expansion(key_ext, int'(Nk));

  always_comb begin
    word_base = {rnd_q, 2'b00};
    round_key = {sched[word_base], sched[word_base + 6'd1],
                 sched[word_base + 6'd2], sched[word_base + 6'd3]};
  end

  // Round key 0 is just the first four key words, taken straight from the input.
  assign round_key0 = bus.in_key[KeyW-1 -: BlockW];
  assign mid_state  = encryption_round(state_q, round_key);

  aes_encrypt_sequencer_final_round u_final_round (
    .state_i     (state_q),
    .round_key_i (round_key),
    .state_o     (final_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      key_q       <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.in_valid) begin
            key_q      <= bus.in_key;
            state_q    <= bus.in_data ^ round_key0;
            rnd_q      <= RoundW'(1);
            fsm_q      <= StRound;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRound: begin
          if (rnd_q == LastRound) begin
            state_q     <= final_state;
            fsm_q       <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= mid_state;
            rnd_q   <= rnd_q + RoundW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            fsm_q       <= StIdle;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  // Intermediate round states are not exposed; out_data reads zero until the result is ready.
  assign bus.out_data  = out_valid_q ? state_q : '0;
  assign bus.busy      = busy_q;
  assign bus.round_idx = rnd_q;

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
module tb_aes_encrypt_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_encrypt_sequencer_if #(.Nk(4)) bus4 ();
  aes_encrypt_sequencer_if #(.Nk(6)) bus6 ();
  aes_encrypt_sequencer_if #(.Nk(8)) bus8 ();

  aes_encrypt_sequencer #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  aes_encrypt_sequencer #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  aes_encrypt_sequencer #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  typedef struct {
    logic [127:0] ct;
    int           acc_cyc;
  } sb_t;

  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  vec_t         vecs[3];
  sb_t          sb4[$];
  int           accept_log[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         prev_valid = 1'b0;
  logic [127:0] drv_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no/unexpected event, expected handshake within bound", name);
  endtask

  // Scoreboard: expectation queued at each accept, compared at each output handshake.
  always @(negedge clk) begin
    sb_t s;
    if (rst) begin
      sb4.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus4.in_valid && bus4.in_ready) begin
        sb4.push_back('{ct: drv_exp, acc_cyc: cyc + 1});
        accept_log.push_back(cyc + 1);
      end
      if (bus4.out_valid && !prev_valid) begin
        if (sb4.size() == 0) fail("unexpected_out_valid");
        else check("latency_nk4", 128'(cyc - sb4[0].acc_cyc), 128'd10);
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (sb4.size() == 0) begin
          fail("unexpected_output");
        end else begin
          s = sb4.pop_front();
          check("ciphertext_nk4", bus4.out_data, s.ct);
        end
      end
      prev_valid = bus4.out_valid;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send4(input logic [127:0] pt, input logic [127:0] key,
                       input logic [127:0] exp, input bit hold);
    int n;
    n = 0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = pt;
    bus4.in_key   = key;
    drv_exp       = exp;
    @(negedge clk);
    while (!bus4.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (!hold) begin
      bus4.in_valid = 1'b0;
      bus4.in_data  = {$urandom, $urandom, $urandom, $urandom};
      bus4.in_key   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (sb4.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int lat6;
    int lat8;

    vecs[0] = '{pt: PtB, key: KeyB, ct: CtB};
    vecs[1] = '{pt: PtC, key: KeyC, ct: CtC1};
    vecs[2] = '{pt: '0, key: '0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    bus4.in_valid = 0; bus4.in_data = '0; bus4.in_key = '0; bus4.out_ready = 0;
    bus6.in_valid = 0; bus6.in_data = '0; bus6.in_key = '0; bus6.out_ready = 0;
    bus8.in_valid = 0; bus8.in_data = '0; bus8.in_key = '0; bus8.out_ready = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 128'(bus4.in_ready), 128'd1);
    check("reset_out_valid", 128'(bus4.out_valid), 128'd0);
    check("reset_busy", 128'(bus4.busy), 128'd0);
    check("reset_out_data", bus4.out_data, 128'd0);
    check("reset_round_idx", 128'(bus4.round_idx), 128'd0);
    check("reset_in_ready_nk6", 128'(bus6.in_ready), 128'd1);
    check("reset_in_ready_nk8", 128'(bus8.in_ready), 128'd1);

    // Table-driven known-answer vectors.
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send4(vecs[i].pt, vecs[i].key, vecs[i].ct, 1'b0);
      drain4();
    end

    // Back-to-back with in_valid held; inputs change right after each accept.
    accept_log.delete();
    send4(PtB, KeyB, CtB, 1'b1);
    send4(PtC, KeyC, CtC1, 1'b0);
    drain4();
    if (accept_log.size() == 2) begin
      check("accept_spacing", 128'(accept_log[1] - accept_log[0]), 128'd12);
    end else begin
      fail("accept_count");
    end

    // Backpressure: result held while out_ready is low; in_valid is ignored meanwhile.
    bus4.out_ready = 1'b0;
    send4(PtC, KeyC, CtC1, 1'b0);
    n = 0;
    while (!bus4.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) fail("out_valid_timeout");
    bus4.in_valid = 1'b1;
    bus4.in_data  = PtB;
    bus4.in_key   = KeyB;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== CtC1 || bus4.in_ready !== 1'b0 ||
          bus4.busy !== 1'b1 || bus4.round_idx !== 4'd10) bad++;
      @(posedge clk);
      #1;
    end
    check("backpressure_hold", 128'(bad), 128'd0);
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 128'(bus4.in_ready), 128'd1);
    check("release_out_valid", 128'(bus4.out_valid), 128'd0);
    check("release_queue_empty", 128'(sb4.size()), 128'd0);

    // Reset while round 5 is in flight.
    send4(PtB, KeyB, CtB, 1'b0);
    n = 0;
    while (bus4.round_idx !== 4'd5 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) fail("round5_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_in_ready", 128'(bus4.in_ready), 128'd1);
    check("midreset_out_valid", 128'(bus4.out_valid), 128'd0);
    check("midreset_round_idx", 128'(bus4.round_idx), 128'd0);
    check("midreset_busy", 128'(bus4.busy), 128'd0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus4.out_valid !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check("midreset_no_output", 128'(bad), 128'd0);
    send4(PtC, KeyC, CtC1, 1'b0);
    drain4();

    // AES-192 and AES-256 latency and result, launched together.
    bus6.in_valid = 1'b1;
    bus6.in_data  = PtC;
    bus6.in_key   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    bus8.in_valid = 1'b1;
    bus8.in_data  = PtC;
    bus8.in_key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    @(posedge clk);
    #1;
    bus6.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    bus6.in_key   = '0;
    bus8.in_key   = '0;
    lat6 = -1;
    lat8 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus6.out_valid && lat6 < 0) lat6 = i;
      if (bus8.out_valid && lat8 < 0) lat8 = i;
    end
    check("latency_nk6", 128'(lat6), 128'd12);
    check("latency_nk8", 128'(lat8), 128'd14);
    check("ciphertext_nk6", bus6.out_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    check("ciphertext_nk8", bus8.out_data, 128'h8ea2b7ca516745bfeafc49904b496089);
    bus6.out_ready = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready_nk6", 128'(bus6.in_ready), 128'd1);
    check("release_in_ready_nk8", 128'(bus8.in_ready), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
